// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer
//   Write-back end of the register-file write port. It takes results from
//   the ALU and the load unit over valid/ready handshakes, queues them in
//   an in-order circular FIFO, and commits one regfile write per cycle. It
//   also exports a pending-write scoreboard and a two-port forwarding
//   lookup over the queued (not yet committed) entries.
//
// Optional feature (macro REGFILE_WB_BYPASS_EN):
//   When the queue is empty and no flush is active, a result is driven
//   straight onto the write port in the same cycle instead of being queued.
//   The ALU wins; if both ports are valid the load is queued. Bypassed
//   results never appear in forwarding or pending_o. With the macro
//   undefined every result passes through the FIFO.
//
// Parameters:
//   XLEN   data width
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   flush_i                   drop every queued entry except the head being committed
//   alu_valid_i/rd_i/data_i   ALU result handshake;  alu_ready_o accepts it
//   ld_valid_i/rd_i/data_i    load result handshake; ld_ready_o accepts it
//   rsW_o, dataW_o, RegWEn_o  regfile write port
//   fwd_rs1_i/fwd_rs2_i       forwarding queries
//   fwd_hit*_o, fwd_data*_o   forwarding results (youngest matching entry)
//   pending_o                 bit r set while a queued entry targets register r
module regfile_wb_writer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_ready_o,
  input  logic            ld_valid_i,
  input  logic [4:0]      ld_rd_i,
  input  logic [XLEN-1:0] ld_data_i,
  output logic            ld_ready_o,
  output logic [4:0]      rsW_o,
  output logic [XLEN-1:0] dataW_o,
  output logic            RegWEn_o,
  input  logic [4:0]      fwd_rs1_i,
  input  logic [4:0]      fwd_rs2_i,
  output logic            fwd_hit1_o,
  output logic            fwd_hit2_o,
  output logic [XLEN-1:0] fwd_data1_o,
  output logic [XLEN-1:0] fwd_data2_o,
  output logic [31:0]     pending_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Control state (reset) and entry storage (not reset).
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] ent_vld;
  logic [4:0]      ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];

  logic [CW-1:0] free;
  logic          alu_fire;
  logic          ld_fire;
  logic          byp_alu;
  logic          byp_ld;
  logic          push_alu;
  logic          push_ld;
  logic          pop;
  logic [PW-1:0] ld_idx;

  // Free slots are judged on the count at the start of the cycle; the
  // head popping this cycle is deliberately not credited. Gating with
  // rst_n_i keeps both readies low while reset is held.
  assign free        = CW'(DEPTH) - count;
  assign alu_ready_o = rst_n_i & ~flush_i & (free >= CW'(1));
  assign ld_ready_o  = rst_n_i & ~flush_i &
                       ((free >= CW'(2)) | ((free == CW'(1)) & ~alu_valid_i));

  assign alu_fire = alu_valid_i & alu_ready_o;
  assign ld_fire  = ld_valid_i  & ld_ready_o;

`ifdef REGFILE_WB_BYPASS_EN
  // Empty queue: the winning result goes straight to the write port.
  // readies already include ~flush_i and rst_n_i.
  assign byp_alu = (count == '0) & alu_fire & (alu_rd_i != 5'd0);
  assign byp_ld  = (count == '0) & ld_fire & ~alu_valid_i & (ld_rd_i != 5'd0);
`else
  assign byp_alu = 1'b0;
  assign byp_ld  = 1'b0;
`endif

  // rd = 0 completes the handshake but never occupies a slot.
  assign push_alu = alu_fire & (alu_rd_i != 5'd0) & ~byp_alu;
  assign push_ld  = ld_fire  & (ld_rd_i  != 5'd0) & ~byp_ld;
  assign pop      = (count != '0);

  // The load lands behind the ALU entry when both push in one cycle.
  assign ld_idx = tail + PW'(push_alu);

  // Commit port: head of the queue, or the bypassed result when empty.
  always_comb begin
    RegWEn_o = 1'b0;
    rsW_o    = '0;
    dataW_o  = '0;
    if (count != '0) begin
      RegWEn_o = 1'b1;
      rsW_o    = ent_rd[head];
      dataW_o  = ent_data[head];
    end else if (byp_alu) begin
      RegWEn_o = 1'b1;
      rsW_o    = alu_rd_i;
      dataW_o  = alu_data_i;
    end else if (byp_ld) begin
      RegWEn_o = 1'b1;
      rsW_o    = ld_rd_i;
      dataW_o  = ld_data_i;
    end
  end

  // Pointer / count / valid-bit update. The flush cycle still commits the
  // head (the write port above ignores flush_i) but leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else if (flush_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (push_alu) ent_vld[tail]   <= 1'b1;
      if (push_ld)  ent_vld[ld_idx] <= 1'b1;
      tail  <= tail + PW'(push_alu) + PW'(push_ld);
      count <= count + CW'(push_alu) + CW'(push_ld) - CW'(pop);
    end
  end

  // Entry payload; qualified by the push strobes, which are already
  // suppressed during flush and reset.
  always_ff @(posedge clk_i) begin
    if (push_alu) begin
      ent_rd[tail]   <= alu_rd_i;
      ent_data[tail] <= alu_data_i;
    end
    if (push_ld) begin
      ent_rd[ld_idx]   <= ld_rd_i;
      ent_data[ld_idx] <= ld_data_i;
    end
  end

  // Forwarding: walk from oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1_o  = 1'b0;
    fwd_hit2_o  = 1'b0;
    fwd_data1_o = '0;
    fwd_data2_o = '0;
    idx         = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && ent_vld[idx]) begin
        if ((fwd_rs1_i != 5'd0) && (ent_rd[idx] == fwd_rs1_i)) begin
          fwd_hit1_o  = 1'b1;
          fwd_data1_o = ent_data[idx];
        end
        if ((fwd_rs2_i != 5'd0) && (ent_rd[idx] == fwd_rs2_i)) begin
          fwd_hit2_o  = 1'b1;
          fwd_data2_o = ent_data[idx];
        end
      end
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pending_o[ent_rd[i]] = 1'b1;
    end
    pending_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_writer.sv
module tb_regfile_wb_writer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic [4:0]      rsw;
  logic [XLEN-1:0] dataw;
  logic            regwen;
  logic [4:0]      q1;
  logic [4:0]      q2;
  logic            hit1;
  logic            hit2;
  logic [XLEN-1:0] fdata1;
  logic [XLEN-1:0] fdata2;
  logic [31:0]     pending;

  regfile_wb_writer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .alu_data_i  (alu_data),
    .alu_ready_o (alu_ready),
    .ld_valid_i  (ld_valid),
    .ld_rd_i     (ld_rd),
    .ld_data_i   (ld_data),
    .ld_ready_o  (ld_ready),
    .rsW_o       (rsw),
    .dataW_o     (dataw),
    .RegWEn_o    (regwen),
    .fwd_rs1_i   (q1),
    .fwd_rs2_i   (q2),
    .fwd_hit1_o  (hit1),
    .fwd_hit2_o  (hit2),
    .fwd_data1_o (fdata1),
    .fwd_data2_o (fdata2),
    .pending_o   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  // Reference: the ordered list of results still owed to the regfile.
  ent_t sb[$];
  logic head_due;
  logic mon_en;
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs computed from the queued-result list.
  task automatic check_state();
    int   free;
    logic e_ar, e_lr, e_h1, e_h2;
    logic [31:0] e_d1, e_d2, e_pend;
    free = DEPTH - sb.size();
    e_ar = !flush && (free >= 1);
    e_lr = !flush && ((free >= 2) || (free == 1 && !alu_valid));
    e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0; e_pend = '0;
    foreach (sb[i]) begin
      e_pend[sb[i].rd] = 1'b1;
      if (q1 != 0 && sb[i].rd == q1) begin e_h1 = 1'b1; e_d1 = sb[i].data; end
      if (q2 != 0 && sb[i].rd == q2) begin e_h2 = 1'b1; e_d2 = sb[i].data; end
    end
    e_pend[0] = 1'b0;
    chk("alu_ready", 32'(alu_ready), 32'(e_ar));
    chk("ld_ready",  32'(ld_ready),  32'(e_lr));
    chk("fwd_hit1",  32'(hit1),      32'(e_h1));
    chk("fwd_data1", fdata1,         e_d1);
    chk("fwd_hit2",  32'(hit2),      32'(e_h2));
    chk("fwd_data2", fdata2,         e_d2);
    chk("pending",   pending,        e_pend);
  endtask

  // One cycle: drive, check combinational outputs, update the reference.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                      input logic fl, input logic [4:0] r1, input logic [4:0] r2);
    logic a_ok, l_ok;
    int   free;
    @(negedge clk);
    #1;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldd;
    flush = fl; q1 = r1; q2 = r2;
    #1;
    check_state();
    free = DEPTH - sb.size();
    head_due = (sb.size() > 0);
    if (fl) begin
      while (sb.size() > 1) void'(sb.pop_back());
    end else begin
      a_ok = av && (free >= 1);
      l_ok = lv && ((free >= 2) || (free == 1 && !av));
      if (a_ok && ard != 0) sb.push_back('{rd: ard, data: ad});
      if (l_ok && lrd != 0) sb.push_back('{rd: lrd, data: ldd});
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
  endtask

  // Commit monitor: pops the owed-result list whenever a write is due.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && mon_en) begin
        chk("commit_en", 32'(regwen), 32'(head_due));
        if (head_due && sb.size() > 0) begin
          e = sb.pop_front();
          chk("commit_rd",   32'(rsw), 32'(e.rd));
          chk("commit_data", dataw,    e.data);
        end else begin
          chk("idle_rd",   32'(rsw), 32'd0);
          chk("idle_data", dataw,    32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; head_due = 1'b0; mon_en = 1'b0;
    rst_n = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    q1 = '0; q2 = '0;
    #12;
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_ld_ready",  32'(ld_ready),  32'd0);
    chk("rst_regwen",    32'(regwen),    32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single ALU write, rd 5.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
    idle();

    // Collision: ALU then load in one cycle.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd1, 5'd2);
    idle(); idle(); idle();

    // Forwarding: two writes to r7 queued; youngest wins; query 0 misses.
    step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0);
    idle(); idle();

    // Flush: three queued, head still commits, rest dropped.
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd3, 5'd4);
    step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b0, 5'd5, 5'd6);
    step(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 1'b1, 5'd5, 5'd6);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd6);
    idle();

    // Back-pressure: both ports valid every cycle.
    for (int i = 0; i < 24; i++)
      step(1'b1, 5'($urandom_range(1, 31)), $urandom,
           1'b1, 5'($urandom_range(1, 31)), $urandom,
           1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    // Randomized traffic with small rd range for forwarding hits.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 29) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    // Reset mid-operation with three entries queued.
    for (int i = 0; i < 2 * DEPTH; i++) idle();
    step(1'b1, 5'd10, 32'h1010, 1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd12, 32'h1212, 1'b1, 5'd13, 32'h1313, 1'b0, 5'd11, 5'd12);
    @(negedge clk);
    #1;
    alu_valid = 1'b0; ld_valid = 1'b0; q1 = 5'd12; q2 = 5'd13;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_regwen",   32'(regwen),    32'd0);
    chk("rst_mid_rsw",      32'(rsw),       32'd0);
    chk("rst_mid_dataw",    dataw,          32'd0);
    chk("rst_mid_alu_rdy",  32'(alu_ready), 32'd0);
    chk("rst_mid_ld_rdy",   32'(ld_ready),  32'd0);
    chk("rst_mid_hit1",     32'(hit1),      32'd0);
    chk("rst_mid_hit2",     32'(hit2),      32'd0);
    chk("rst_mid_fdata1",   fdata1,         32'd0);
    chk("rst_mid_fdata2",   fdata2,         32'd0);
    chk("rst_mid_pending",  pending,        32'd0);
    sb.delete();
    head_due = 1'b0;
    #4;
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd12, 5'd13);
    chk("post_rst_alu_rdy", 32'(alu_ready), 32'd1);
    chk("post_rst_ld_rdy",  32'(ld_ready),  32'd1);
    chk("post_rst_pending", pending,        32'd0);

    // Drain and make sure nothing is left owed.
    for (int i = 0; i < 2 * DEPTH && sb.size() > 0; i++) idle();
    idle();
    chk("drain_left", 32'(sb.size()), 32'd0);
    @(negedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_writer.md
Name: regfile_wb_writer

Overview:
- Write-back end of the register-file write port: sole driver of the regfile's rsW/dataW/RegWEn inputs.
- Accepts results from two producers, the ALU and the load unit, through valid/ready handshakes.
- Serialises the results through an in-order FIFO and commits one write per cycle.
- Exports a pending-write scoreboard and a forwarding lookup so decode can read results not yet committed.

Parameters:
- XLEN, 32, data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous drop of all queued, uncommitted entries.
- alu_valid_i  in  1  ALU result valid.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- alu_ready_o  out  1  ALU result accepted this cycle.
- ld_valid_i  in  1  load result valid.
- ld_rd_i  in  5  load destination register.
- ld_data_i  in  XLEN  load data.
- ld_ready_o  out  1  load result accepted this cycle.
- rsW_o  out  5  regfile write index.
- dataW_o  out  XLEN  regfile write data.
- RegWEn_o  out  1  regfile write enable.
- fwd_rs1_i  in  5  forwarding query, port 1.
- fwd_rs2_i  in  5  forwarding query, port 2.
- fwd_hit1_o  out  1  port 1 query matches a queued entry.
- fwd_hit2_o  out  1  port 2 query matches a queued entry.
- fwd_data1_o  out  XLEN  data for port 1 on a hit.
- fwd_data2_o  out  XLEN  data for port 2 on a hit.
- pending_o  out  32  bit r set while any queued entry targets register r.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - FIFO pointers and count cleared; entry valid bits cleared.
  - Every output reads 0 while reset is held, including both ready outputs.
  - After release, count = 0, so both readies are 1.
- FIFO storage: circular buffer of {rd, data}; count has range 0..DEPTH.
- Enqueue:
  - free = DEPTH - count, evaluated at the start of the cycle; the same-cycle dequeue is not credited.
  - alu_ready_o = (free >= 1).
  - ld_ready_o = (free >= 2) or (free == 1 and not alu_valid_i). The ALU has fixed priority.
  - A transfer occurs when valid and ready are both high.
  - Both ports accepted in one cycle: the ALU entry is written first (older), the load entry second.
  - Results with rd = 0 are accepted (handshake completes) but not stored and do not consume a slot. The ready equations above are unchanged by this.
- Dequeue/commit:
  - Whenever count > 0: RegWEn_o = 1, rsW_o = head.rd, dataW_o = head.data. The regfile captures them on the same rising edge.
  - The head pops on that edge.
  - When count = 0, RegWEn_o, rsW_o and dataW_o are all 0.
  - Latency: result accepted in cycle N (empty FIFO) is committed at the end of cycle N+1.
- Simultaneous enqueue and dequeue in one cycle:
  - count_next = count + pushes - pop.
  - Pointers wrap modulo DEPTH.
- Forwarding, combinational from the queued entries:
  - Hit when a queued entry's rd equals the query and the query is not 0.
  - The data returned is the youngest matching entry.
  - Query 0 never hits; fwd_data reads 0 on a miss.
  - Same-cycle input-port values are not forwarded.
- pending_o: OR over valid entries of the one-hot of rd; bit 0 is always 0.
- Flush (flush_i high at a clock edge):
  - count, pointers and valid bits go to 0; no enqueue that cycle; readies forced 0 that cycle.
  - The head entry presented during the flush cycle is still committed (RegWEn_o unchanged that cycle); all other entries are dropped.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: when count = 0 and no flush is active, a result on the selected port is driven straight to rsW_o/dataW_o/RegWEn_o in the same cycle and is not stored. The ALU has priority; if both ports are valid, the load is queued. Latency becomes 0. Forwarding and pending_o are unaffected by the bypassed result.
- Undefined: every result passes through the FIFO; latency is 1.

Test Plan:
- Reset mid-operation: queue 3 entries, pulse rst_n_i low between edges -> all outputs 0 immediately; after release, pending_o = 0 and both readies are 1.
- Single ALU write: rd = 5, data 0xDEADBEEF in cycle N -> RegWEn_o = 1, rsW_o = 5, dataW_o = 0xDEADBEEF in cycle N+1; pending_o[5] high only during N+1; 0 in N+2. With the bypass macro, the same values appear in cycle N.
- Collision: ALU rd = 1 / 0x11 and load rd = 2 / 0x22 in the same cycle, FIFO empty -> commits rd = 1 then rd = 2 on consecutive cycles.
- Back-pressure: both ports valid every cycle with rd != 0 -> ld_ready_o goes low once free < 2 with the ALU valid; no entry lost or reordered; count never exceeds DEPTH (4).
- Forwarding: queue rd = 7 / 0xA, then rd = 7 / 0xB; query fwd_rs1_i = 7 -> hit, data 0xB. Query 0 -> no hit. rd = 0 input -> no write, no pending bit.
- Flush: queue 3 entries, assert flush_i -> head commits that cycle, remaining 2 are never written, pending_o = 0 on the next cycle.
